// File: rtl/cpu_q8_pkg.sv
// Shared constants for the Q8 core: address/nibble widths, return-stack depth,
// the repurposed NOP opcodes and the reset vector.
package cpu_q8_pkg;

    localparam int unsigned Q8_PM_ADDR_W   = 8;
    localparam int unsigned Q8_NIBBLE_W    = 4;
    localparam int unsigned Q8_STACK_DEPTH = 4;

    localparam logic [7:0] Q8_OP_NOPC8 = 8'hC8;  // link (call prefix)
    localparam logic [7:0] Q8_OP_NOPCF = 8'hCF;  // return
    localparam logic [7:0] Q8_OP_NOPD8 = 8'hD8;  // clear stack error
    localparam logic [7:0] Q8_OP_NOPDF = 8'hDF;  // halt

    localparam int unsigned Q8_RESET_VECTOR = 0;

    function automatic logic is_taken_jump(input logic jmp, input logic jmp_nz,
                                           input logic dont_jmp);
        return jmp | (jmp_nz & ~dont_jmp);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular LIFO of return addresses: pushing when full overwrites the oldest
// entry, popping when empty is a no-op; both report through ovf/unf.
module return_stack
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   top,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic             full;
    logic             empty;

    assign full  = (depth == DEPTH_W'(DEPTH));
    assign empty = (depth == '0);
    assign top   = mem[sp - PTR_W'(1)];
    assign ovf   = push & full;
    assign unf   = pop & empty;

    // sp wraps naturally because DEPTH is a power of two, so a full push
    // lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sp    <= '0;
            depth <= '0;
        end else if (push) begin
            sp <= sp + PTR_W'(1);
            if (!full) begin
                depth <= depth + DEPTH_W'(1);
            end
        end else if (pop && !empty) begin
            sp    <= sp - PTR_W'(1);
            depth <= depth - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset && push) begin
            mem[sp] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer_q8.sv
// Program sequencer for the Q8 core: generates pm_addr, tracks pc, and adds
// halt plus a linked call/return mechanism over a small hardware return stack.
module program_sequencer_q8
    import cpu_q8_pkg::*;
#(
    parameter int unsigned PM_ADDR_W   = Q8_PM_ADDR_W,
    parameter int unsigned NIBBLE_W    = Q8_NIBBLE_W,
    parameter int unsigned STACK_DEPTH = Q8_STACK_DEPTH,
    localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 jmp,
    input  logic                 jmp_nz,
    input  logic                 dont_jmp,
    input  logic [NIBBLE_W-1:0]  ir_nibble,
    input  logic                 NOPC8,
    input  logic                 NOPCF,
    input  logic                 NOPD8,
    input  logic                 NOPDF,
    output logic [PM_ADDR_W-1:0] pm_addr,
    output logic [PM_ADDR_W-1:0] pc,
    output logic [PM_ADDR_W-1:0] from_PS,
    output logic [DEPTH_W-1:0]   stack_depth,
    output logic                 stack_err,
    output logic                 halted
);

    logic [PM_ADDR_W-1:0] pc_inc;
    logic [PM_ADDR_W-1:0] jump_target;
    logic [PM_ADDR_W-1:0] stack_top;
    logic                 link_pending;
    logic                 taken;
    logic                 halt_now;
    logic                 push;
    logic                 pop;
    logic                 ovf;
    logic                 unf;

    assign pc_inc      = pc + PM_ADDR_W'(1);
    assign jump_target = {ir_nibble, {(PM_ADDR_W - NIBBLE_W){1'b0}}};
    assign taken       = is_taken_jump(jmp, jmp_nz, dont_jmp);
    assign halt_now    = halted | NOPDF;
    assign from_PS     = pc;

    // Stack traffic is suppressed during reset and while halting.
    assign push = ~sync_reset & ~halt_now & link_pending & taken & ~NOPCF;
    assign pop  = ~sync_reset & ~halt_now & NOPCF;

    always_comb begin
        pm_addr = pc_inc;
        if (sync_reset) begin
            pm_addr = PM_ADDR_W'(Q8_RESET_VECTOR);
        end else if (halt_now) begin
            pm_addr = pc;
        end else if (NOPCF) begin
            pm_addr = (stack_depth != '0) ? stack_top : pc_inc;
        end else if (taken) begin
            pm_addr = jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc           <= PM_ADDR_W'(Q8_RESET_VECTOR);
            link_pending <= 1'b0;
            stack_err    <= 1'b0;
            halted       <= 1'b0;
        end else begin
            pc <= pm_addr;
            if (!halt_now) begin
                link_pending <= NOPC8;
            end
            if (ovf || unf) begin
                stack_err <= 1'b1;
            end else if (NOPD8 && !halt_now) begin
                stack_err <= 1'b0;
            end
            if (NOPDF) begin
                halted <= 1'b1;
            end
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PM_ADDR_W)
    ) u_return_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (push),
        .pop        (pop),
        .din        (pc_inc),
        .top        (stack_top),
        .depth      (stack_depth),
        .ovf        (ovf),
        .unf        (unf)
    );

endmodule

// File: tb/tb_program_sequencer_q8.sv
// Directed scoreboard bench for program_sequencer_q8: stimulus queues the
// expected outputs, a negedge monitor pops and compares them.
module tb_program_sequencer_q8;

    localparam int X = -1;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       jmp = 1'b0;
    logic       jmp_nz = 1'b0;
    logic       dont_jmp = 1'b0;
    logic [3:0] ir_nibble = 4'h0;
    logic       NOPC8 = 1'b0;
    logic       NOPCF = 1'b0;
    logic       NOPD8 = 1'b0;
    logic       NOPDF = 1'b0;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic [7:0] from_PS;
    logic [2:0] stack_depth;
    logic       stack_err;
    logic       halted;

    typedef struct {
        int id;
        int addr;
        int pc;
        int depth;
        int err;
        int halt;
    } exp_t;

    exp_t q[$];
    int   step_id = 0;
    int   tests = 0;
    int   fails = 0;

    program_sequencer_q8 dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .ir_nibble   (ir_nibble),
        .NOPC8       (NOPC8),
        .NOPCF       (NOPCF),
        .NOPD8       (NOPD8),
        .NOPDF       (NOPDF),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .from_PS     (from_PS),
        .stack_depth (stack_depth),
        .stack_err   (stack_err),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string fld, input int got, input int want);
        if (want != X) begin
            tests++;
            if (got != want) begin
                fails++;
                $display("FAIL step%0d %s: got %0h, expected %0h", id, fld, got, want);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "pm_addr", int'(pm_addr), e.addr);
            chk(e.id, "pc", int'(pc), e.pc);
            chk(e.id, "from_PS", int'(from_PS), e.pc);
            chk(e.id, "stack_depth", int'(stack_depth), e.depth);
            chk(e.id, "stack_err", int'(stack_err), e.err);
            chk(e.id, "halted", int'(halted), e.halt);
        end
    end

    task automatic drive(input logic rst, input logic j, input logic jnz, input logic dj,
                         input logic [3:0] nib, input logic c8, input logic cf,
                         input logic d8, input logic df, input int e_addr, input int e_pc,
                         input int e_depth, input int e_err, input int e_halt);
        @(posedge clk);
        #1;
        sync_reset = rst;
        jmp        = j;
        jmp_nz     = jnz;
        dont_jmp   = dj;
        ir_nibble  = nib;
        NOPC8      = c8;
        NOPCF      = cf;
        NOPD8      = d8;
        NOPDF      = df;
        q.push_back('{step_id, e_addr, e_pc, e_depth, e_err, e_halt});
        step_id++;
    endtask

    task automatic idle(input int a, input int p, input int d, input int e, input int h);
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, a, p, d, e, h);
    endtask

    task automatic do_jmp(input logic [3:0] nib, input int a, input int p, input int d);
        drive(0, 1, 0, 0, nib, 0, 0, 0, 0, a, p, d, X, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and free-running increment
        drive(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, X, X, X, X);
        idle(8'h01, 8'h00, 0, 0, 0);
        idle(8'h02, 8'h01, 0, 0, 0);
        idle(8'h03, 8'h02, 0, 0, 0);
        idle(8'h04, 8'h03, 0, 0, 0);
        idle(8'h05, 8'h04, 0, 0, 0);

        // Jumps: unconditional, untaken and taken conditional
        do_jmp(4'hA, 8'hA0, 8'h05, 0);
        drive(0, 0, 1, 1, 4'h3, 0, 0, 0, 0, 8'hA1, 8'hA0, 0, 0, 0);
        drive(0, 0, 1, 0, 4'h3, 0, 0, 0, 0, 8'h30, 8'hA1, 0, 0, 0);

        // Wrap from FF to 00
        do_jmp(4'hF, 8'hF0, 8'h30, 0);
        for (int i = 0; i < 15; i++) idle(8'hF1 + i, 8'hF0 + i, 0, 0, 0);
        idle(8'h00, 8'hFF, 0, 0, 0);

        // Single linked call and return
        do_jmp(4'h1, 8'h10, 8'h00, 0);
        drive(0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 8'h11, 8'h10, 0, 0, 0);
        do_jmp(4'h4, 8'h40, 8'h11, 0);
        idle(8'h41, 8'h40, 1, 0, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 8'h12, 8'h41, 1, 0, 0);
        idle(8'h13, 8'h12, 0, 0, 0);

        // Five linked calls overflow a 4-deep stack
        do_jmp(4'h0, 8'h00, 8'h13, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 4'h0, 1, 0, 0, 0, k * 16 + 1, k * 16, k, 0, 0);
            do_jmp(4'(k + 1), (k + 1) * 16, k * 16 + 1, k);
        end
        idle(8'h51, 8'h50, 4, 1, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 8'h42, 8'h51, 4, 1, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 8'h32, 8'h42, 3, 1, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 8'h22, 8'h32, 2, 1, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 8'h12, 8'h22, 1, 1, 0);
        // Underflow: falls through to pc+1
        drive(0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 8'h13, 8'h12, 0, 1, 0);
        idle(8'h14, 8'h13, 0, 1, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 8'h15, 8'h14, 0, 1, 0);
        idle(8'h16, 8'h15, 0, 0, 0);

        // Link followed by untaken jmp_nz: no push; then taken jmp_nz: push
        drive(0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 8'h17, 8'h16, 0, 0, 0);
        drive(0, 0, 1, 1, 4'h7, 0, 0, 0, 0, 8'h18, 8'h17, 0, 0, 0);
        idle(8'h19, 8'h18, 0, 0, 0);
        drive(0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 8'h1A, 8'h19, 0, 0, 0);
        drive(0, 0, 1, 0, 4'h6, 0, 0, 0, 0, 8'h60, 8'h1A, 0, 0, 0);
        idle(8'h61, 8'h60, 1, 0, 0);
        do_jmp(4'h2, 8'h20, 8'h61, 1);

        // Halt: address frozen, jumps and returns ignored
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h20, 8'h20, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, (i % 2 == 0), 0, 0, 4'h9, 0, (i % 2 == 1), 0, 0,
                  8'h20, 8'h20, 1, 0, 1);
        end
        drive(1, 1, 0, 0, 4'h9, 0, 0, 0, 0, 8'h00, 8'h20, 1, 0, 1);
        idle(8'h01, 8'h00, 0, 0, 0);

        // Reset while a link is pending cancels it
        drive(0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 8'h02, 8'h01, 0, 0, 0);
        drive(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0);
        do_jmp(4'h3, 8'h30, 8'h00, 0);
        idle(8'h31, 8'h30, 0, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_sequencer_q8.md
Name: program_sequencer_q8

Overview:
- Upstream neighbour of the Q8 instruction decoder. It generates the program memory address `pm_addr`.
- Program memory (synchronous read) returns `next_instr`, which the decoder registers into `ir`.
- Consumes the decoder's `jmp`, `jmp_nz`, `ir_nibble`, and the repurposed NOP strobes:
  - NOPC8 = link (call prefix)
  - NOPCF = return
  - NOPD8 = clear stack error
  - NOPDF = halt
- Adds a small hardware return-address stack to the baseline `pc`/jump sequencer.

Parameters:
- PM_ADDR_W, 8, width of `pc`/`pm_addr`.
- NIBBLE_W, 4, width of `ir_nibble`. Jump target is `{ir_nibble, (PM_ADDR_W-NIBBLE_W)'b0}`.
- STACK_DEPTH, 4, number of return-address entries (power of 2).

Ports:
- clk  in  1  system clock.
- sync_reset  in  1  synchronous, active-high reset.
- jmp  in  1  unconditional jump (from decoder).
- jmp_nz  in  1  conditional jump (from decoder).
- dont_jmp  in  1  ALU zero flag; 1 suppresses `jmp_nz`.
- ir_nibble  in  NIBBLE_W  jump target high bits.
- NOPC8  in  1  link: the next instruction, if it is a taken jump, pushes a return address.
- NOPCF  in  1  return: pop stack into `pm_addr`.
- NOPD8  in  1  clear `stack_err`.
- NOPDF  in  1  halt.
- pm_addr  out  PM_ADDR_W  combinational program memory address.
- pc  out  PM_ADDR_W  registered address of the instruction now in `ir`.
- from_PS  out  PM_ADDR_W  debug copy of `pc`.
- stack_depth  out  clog2(STACK_DEPTH)+1  number of valid entries.
- stack_err  out  1  sticky overflow/underflow flag.
- halted  out  1  high while halted.

Behaviour:
- Registers update on posedge `clk`: `pc`, the stack, the stack pointer, `link_pending`, `stack_err`, `halted`. `pm_addr` is combinational.
- Every cycle, `pc <= pm_addr`.
- Reset values (`sync_reset` = 1):
  - `pm_addr` = 0 (combinational, same cycle).
  - `pc`, `stack_depth`, `stack_err`, `halted`, `link_pending` are cleared to 0 on the next edge.
  - Stack contents need not be cleared.
- Reset has top priority, including mid-halt and mid-link.
- `pm_addr` priority (first match wins):
  1. `sync_reset` → 0.
  2. `halted` or `NOPDF` → `pc` (re-fetch the same word).
  3. `NOPCF` with `stack_depth` > 0 → top of stack.
  4. `NOPCF` with `stack_depth` = 0 → `pc`+1.
  5. `jmp` → `{ir_nibble, 0}`.
  6. `jmp_nz` with `dont_jmp` = 0 → `{ir_nibble, 0}`.
  7. Otherwise → `pc`+1.
- `pc`+1 wraps from 8'hFF to 8'h00 silently.
- `halted` is set by `NOPDF` and stays set until reset.
  - While halted, all other strobes are ignored.
  - No stack or `link_pending` changes occur while halted.
- `link_pending`:
  - Set on any cycle with `NOPC8` = 1.
  - Otherwise cleared every cycle; it lives for exactly one following instruction.
- Push: occurs when `link_pending` = 1 and the current instruction is a taken jump (`jmp`, or `jmp_nz` with `dont_jmp` = 0).
  - Pushed value is `pc`+1 (address after the jump).
  - An untaken `jmp_nz`, or any non-jump after `NOPC8`, pushes nothing.
- Overflow: a push when `stack_depth` = STACK_DEPTH overwrites the oldest entry (circular), keeps the depth at STACK_DEPTH, and sets `stack_err`.
- Underflow: a pop at depth 0 leaves the depth at 0 and sets `stack_err`.
- `NOPD8` clears `stack_err`. If an error event occurs in the same cycle, set wins.
- Simultaneous events:
  - The decoder guarantees at most one of `jmp`/`jmp_nz`/NOP strobes per cycle.
  - A push and a pop in the same cycle are therefore impossible.
  - `NOPCF` while `link_pending` = 1: pop normally, no push.
- Latency: one instruction per cycle, no bubbles. Jumps take effect on the next fetch, with no delay slot.

Decomposition:
- Shared package `cpu_q8_pkg`: PM_ADDR_W, NIBBLE_W, STACK_DEPTH, the opcode constants for C8/CF/D8/DF, and the reset vector (0).
- One sub-module, `return_stack`: a parameterised circular LIFO.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `top`, `depth`, `ovf`, `unf`.
- Address muxing, halt logic and link logic stay in `program_sequencer_q8`.

Test Plan:
- Reset, then 3 idle cycles → `pm_addr` 0,1,2,3; `pc` lags by one; `stack_err` = 0. Starting with `pc` = 8'hFF → `pm_addr` = 8'h00.
- At `pc` = 8'h05: `jmp`, `ir_nibble` = 4'hA → `pm_addr` = 8'hA0. At `pc` = 8'hA0: `jmp_nz`, `ir_nibble` = 3, `dont_jmp` = 1 → `pm_addr` = 8'hA1. Same with `dont_jmp` = 0 → 8'h30.
- `NOPC8` at `pc` = 8'h10, `jmp` nibble 4 at 8'h11 → `pm_addr` = 8'h40, `stack_depth` = 1. Later `NOPCF` → `pm_addr` = 8'h12, `stack_depth` = 0.
- Five linked calls from `pc` = 8'h01/11/21/31/41 → `stack_depth` stays 4, `stack_err` = 1. Four returns yield 8'h42, 8'h32, 8'h22, 8'h12. A fifth return → `pm_addr` = `pc`+1, `stack_err` still 1. `NOPD8` → `stack_err` = 0.
- `NOPC8` followed by an untaken `jmp_nz` (`dont_jmp` = 1) → no push, `stack_depth` unchanged.
- `NOPDF` at `pc` = 8'h20 → `pm_addr` held at 8'h20 for 10 cycles despite `jmp` pulses. `sync_reset` → `pm_addr` = 0 same cycle; `halted` = 0 after the edge.
